capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Read-clock-domain controller that sequences one acquisition through the capture storage block: arm, wait for trigger, strobe storage, wait for fill, then drain the storage's byte stream to the UART transmitter.
- Sits between host command decode, the storage block and the UART TX.
- Owns WriteStrobe and the storage read enable, and reports progress and byte count to the host.

Parameters:
- STROBE_LEN, 4, cycles WriteStrobe is held high (min 1).
- TRIG_TIMEOUT, 50000000, cycles allowed in WAIT_TRIG before abandoning; 0 disables the timeout.
- TRIG_CNT_W, 26, width of the trigger-timeout counter (must hold TRIG_TIMEOUT).
- VALID_TIMEOUT, 4, cycles allowed for StorageDataValid after a read request.
- BYTE_CNT_W, 16, width of ByteCount.

Ports:
- Clock  in  1  read/system clock; the storage ReadClock.
- Reset  in  1  synchronous, active-high.
- ArmCmd  in  1  one-cycle pulse from the host: start an acquisition.
- AbortCmd  in  1  one-cycle pulse from the host: cancel the acquisition.
- TrigEnable  in  1  1 = wait for ExtTrigger; 0 = strobe immediately after ready.
- ExtTrigger  in  1  trigger level, already synchronous to Clock; rising edge is used.
- StorageState  in  2  storage state: 00 ready, 01 storing, 10 sending.
- FifoNotFull  in  1  from storage.
- DataReadyToSend  in  1  storage converter not empty.
- StorageDataIn  in  8  storage byte output.
- StorageDataValid  in  1  storage byte valid.
- TxBusy  in  1  UART transmitter busy.
- WriteStrobe  out  1  to storage.
- StorageReadEnable  out  1  to storage ReadEnable.
- TxData  out  8  byte to the UART.
- TxStart  out  1  one-cycle UART start pulse.
- ByteCount  out  BYTE_CNT_W  bytes sent this acquisition; saturates at all-ones.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse on normal completion.
- TimedOut  out  1  one-cycle pulse on trigger timeout.
- SeqState  out  4  current state encoding, for debug.

Behaviour:
- Reset: state IDLE; every output 0; all counters 0. Reset mid-operation returns to IDLE on the next edge and drops any byte in flight.
- Trigger edge detect: previous ExtTrigger is registered; rising edge = current & ~previous. The register also updates while in IDLE.
- IDLE: ArmCmd accepted -> clear ByteCount -> WAIT_READY. ArmCmd outside IDLE is ignored.
- WAIT_READY: stay until StorageState==00 and FifoNotFull. Then go to WAIT_TRIG if TrigEnable=1, else STROBE.
- WAIT_TRIG: the timeout counter increments each cycle.
  - Trigger rising edge -> STROBE.
  - Counter reaching TRIG_TIMEOUT-1 with TRIG_TIMEOUT!=0 -> pulse TimedOut -> IDLE.
  - Edge and timeout in the same cycle: the edge wins.
- STROBE: WriteStrobe=1 for exactly STROBE_LEN cycles, then -> WAIT_FULL with WriteStrobe=0.
- WAIT_FULL: stay until StorageState==10, then -> READ_REQ. No timeout.
- READ_REQ:
  - If DataReadyToSend=1 and TxBusy=0: assert StorageReadEnable for exactly this one cycle -> READ_WAIT.
  - Else if DataReadyToSend=0 and StorageState==00: -> FINISH.
- READ_WAIT: count cycles.
  - StorageDataValid=1: register StorageDataIn into TxData, pulse TxStart next cycle, increment ByteCount (saturating) -> TX_WAIT.
  - No valid within VALID_TIMEOUT cycles: -> READ_REQ with no count and no TxStart.
- TX_WAIT: the first cycle is a guard and is always spent. Afterwards leave when TxBusy==0 -> READ_REQ. TxData holds stable throughout.
- FINISH: pulse Done for one cycle -> IDLE. ByteCount holds its value until the next accepted Arm.
- Abort:
  - AbortCmd in WAIT_READY, WAIT_TRIG or STROBE: drop WriteStrobe next cycle -> IDLE.
  - AbortCmd in WAIT_FULL, READ_REQ, READ_WAIT or TX_WAIT: -> FLUSH.
  - AbortCmd in IDLE or FLUSH: ignored.
- FLUSH:
  - Wait for StorageState==10, then read with one-cycle StorageReadEnable pulses, each followed by a wait for valid or timeout. TxStart stays 0 and ByteCount is unchanged.
  - Exit to IDLE once DataReadyToSend=0 and StorageState==00. No Done pulse.
  - FLUSH is entered only with the storage already storing or sending, so the storage is always drained back to ready.
- Simultaneous ArmCmd and AbortCmd: Abort wins; Arm is discarded.
- Only one outstanding storage read at any time; StorageReadEnable is never high on two consecutive cycles.
- Byte order on the UART equals storage output order. The first four bytes are the storage signature FF 80 7F 00.

Test Plan:
- TrigEnable=0, Arm; storage model fills and offers 12 bytes -> WriteStrobe high 4 cycles. 12 TxStart pulses with bytes FF,80,7F,00 then the data payload in order. ByteCount=12, one Done pulse, then IDLE.
- TrigEnable=1, TRIG_TIMEOUT=100, no trigger -> TimedOut pulse exactly 100 cycles after entering WAIT_TRIG. WriteStrobe never asserted; Busy=0 afterwards.
- TrigEnable=1, ExtTrigger rises on the same cycle the timeout expires -> STROBE entered; no TimedOut pulse.
- TxBusy held high 50 cycles after each TxStart -> no StorageReadEnable while TxBusy=1, and never on back-to-back cycles; all bytes delivered.
- AbortCmd during READ_REQ with 8 bytes remaining -> exactly 8 further StorageReadEnable pulses, no TxStart, ByteCount frozen, IDLE once storage reports 00. A following Arm starts cleanly.
- Reset asserted in TX_WAIT -> next cycle all outputs 0 and SeqState=IDLE. Simultaneous Arm and Abort in IDLE -> stays in IDLE.

Source files
------------

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : capture_sequencer
// Purpose  : Runs one acquisition through the capture storage: arm, trigger,
//            strobe, wait for fill, then drain the stored bytes to the UART.
// Revision : 1.0  initial release
// ============================================================================
module capture_sequencer #(
    parameter int STROBE_LEN    = 4,
    parameter int TRIG_TIMEOUT  = 50000000,
    parameter int TRIG_CNT_W    = 26,
    parameter int VALID_TIMEOUT = 4,
    parameter int BYTE_CNT_W    = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ArmCmd,
    input  logic                  AbortCmd,
    input  logic                  TrigEnable,
    input  logic                  ExtTrigger,
    input  logic [1:0]            StorageState,
    input  logic                  FifoNotFull,
    input  logic                  DataReadyToSend,
    input  logic [7:0]            StorageDataIn,
    input  logic                  StorageDataValid,
    input  logic                  TxBusy,
    output logic                  WriteStrobe,
    output logic                  StorageReadEnable,
    output logic [7:0]            TxData,
    output logic                  TxStart,
    output logic [BYTE_CNT_W-1:0] ByteCount,
    output logic                  Busy,
    output logic                  Done,
    output logic                  TimedOut,
    output logic [3:0]            SeqState
);

    localparam logic [3:0] c_IDLE       = 4'd0;
    localparam logic [3:0] c_WAIT_READY = 4'd1;
    localparam logic [3:0] c_WAIT_TRIG  = 4'd2;
    localparam logic [3:0] c_STROBE     = 4'd3;
    localparam logic [3:0] c_WAIT_FULL  = 4'd4;
    localparam logic [3:0] c_READ_REQ   = 4'd5;
    localparam logic [3:0] c_READ_WAIT  = 4'd6;
    localparam logic [3:0] c_TX_WAIT    = 4'd7;
    localparam logic [3:0] c_FINISH     = 4'd8;
    localparam logic [3:0] c_FLUSH      = 4'd9;
    localparam logic [3:0] c_FLUSH_WAIT = 4'd10;

    localparam logic [1:0] c_ST_READY   = 2'b00;
    localparam logic [1:0] c_ST_SENDING = 2'b10;

    localparam int c_CNT_MAX = (STROBE_LEN > VALID_TIMEOUT) ? STROBE_LEN : VALID_TIMEOUT;
    localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX);

    localparam logic [c_CNT_W-1:0]    c_STROBE_LAST = c_CNT_W'(STROBE_LEN - 1);
    localparam logic [c_CNT_W-1:0]    c_VALID_LAST  = c_CNT_W'(VALID_TIMEOUT - 1);
    localparam logic [TRIG_CNT_W-1:0] c_TRIG_LAST   =
        TRIG_CNT_W'((TRIG_TIMEOUT == 0) ? 0 : TRIG_TIMEOUT - 1);

    logic [3:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [TRIG_CNT_W-1:0] r_trigCnt;
    logic                  r_trigPrev;
    logic                  r_writeStrobe;
    logic                  r_readEnable;
    logic [7:0]            r_txData;
    logic                  r_txStart;
    logic [BYTE_CNT_W-1:0] r_byteCount;
    logic                  r_done;
    logic                  r_timedOut;

    logic w_trigRise;
    logic w_storageReady;
    logic w_storageSending;
    logic w_drained;

    assign w_trigRise       = ExtTrigger & ~r_trigPrev;
    assign w_storageReady   = (StorageState == c_ST_READY);
    assign w_storageSending = (StorageState == c_ST_SENDING);
    assign w_drained        = ~DataReadyToSend & w_storageReady;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_trigCnt     <= '0;
            r_trigPrev    <= 1'b0;
            r_writeStrobe <= 1'b0;
            r_readEnable  <= 1'b0;
            r_txData      <= '0;
            r_txStart     <= 1'b0;
            r_byteCount   <= '0;
            r_done        <= 1'b0;
            r_timedOut    <= 1'b0;
        end else begin
            r_trigPrev   <= ExtTrigger;
            r_readEnable <= 1'b0;
            r_txStart    <= 1'b0;
            r_done       <= 1'b0;
            r_timedOut   <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (ArmCmd && !AbortCmd) begin
                        r_byteCount <= '0;
                        r_state     <= c_WAIT_READY;
                    end
                end

                c_WAIT_READY: begin
                    if (AbortCmd) begin
                        r_state <= c_IDLE;
                    end else if (w_storageReady && FifoNotFull) begin
                        if (TrigEnable) begin
                            r_trigCnt <= '0;
                            r_state   <= c_WAIT_TRIG;
                        end else begin
                            r_cnt         <= '0;
                            r_writeStrobe <= 1'b1;
                            r_state       <= c_STROBE;
                        end
                    end
                end

                // Trigger edge is tested before the timeout so it wins a tie.
                c_WAIT_TRIG: begin
                    if (AbortCmd) begin
                        r_state <= c_IDLE;
                    end else if (w_trigRise) begin
                        r_cnt         <= '0;
                        r_writeStrobe <= 1'b1;
                        r_state       <= c_STROBE;
                    end else if ((TRIG_TIMEOUT != 0) && (r_trigCnt == c_TRIG_LAST)) begin
                        r_timedOut <= 1'b1;
                        r_state    <= c_IDLE;
                    end else begin
                        r_trigCnt <= r_trigCnt + 1'b1;
                    end
                end

                c_STROBE: begin
                    if (AbortCmd) begin
                        r_writeStrobe <= 1'b0;
                        r_state       <= c_IDLE;
                    end else if (r_cnt == c_STROBE_LAST) begin
                        r_writeStrobe <= 1'b0;
                        r_state       <= c_WAIT_FULL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_WAIT_FULL: begin
                    if (AbortCmd) begin
                        r_state <= c_FLUSH;
                    end else if (w_storageSending) begin
                        r_state <= c_READ_REQ;
                    end
                end

                c_READ_REQ: begin
                    if (AbortCmd) begin
                        r_state <= c_FLUSH;
                    end else if (DataReadyToSend && !TxBusy) begin
                        r_readEnable <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= c_READ_WAIT;
                    end else if (w_drained) begin
                        r_done  <= 1'b1;
                        r_state <= c_FINISH;
                    end
                end

                // An abort with a read still outstanding lets that read
                // complete in FLUSH_WAIT before any new read is issued.
                c_READ_WAIT: begin
                    if (AbortCmd) begin
                        if (StorageDataValid || (r_cnt == c_VALID_LAST)) begin
                            r_state <= c_FLUSH;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= c_FLUSH_WAIT;
                        end
                    end else if (StorageDataValid) begin
                        r_txData  <= StorageDataIn;
                        r_txStart <= 1'b1;
                        if (r_byteCount != '1) begin
                            r_byteCount <= r_byteCount + 1'b1;
                        end
                        r_cnt   <= '0;
                        r_state <= c_TX_WAIT;
                    end else if (r_cnt == c_VALID_LAST) begin
                        r_state <= c_READ_REQ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // The first cycle is spent unconditionally: TxBusy has not yet
                // responded to the start pulse.
                c_TX_WAIT: begin
                    if (AbortCmd) begin
                        r_state <= c_FLUSH;
                    end else if (r_cnt == '0) begin
                        r_cnt <= c_CNT_W'(1);
                    end else if (!TxBusy) begin
                        r_state <= c_READ_REQ;
                    end
                end

                c_FINISH: begin
                    r_state <= c_IDLE;
                end

                c_FLUSH: begin
                    if (w_storageSending && DataReadyToSend) begin
                        r_readEnable <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= c_FLUSH_WAIT;
                    end else if (w_drained) begin
                        r_state <= c_IDLE;
                    end
                end

                c_FLUSH_WAIT: begin
                    if (StorageDataValid || (r_cnt == c_VALID_LAST)) begin
                        r_state <= c_FLUSH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_writeStrobe <= 1'b0;
                    r_state       <= c_IDLE;
                end
            endcase
        end
    end

    assign WriteStrobe       = r_writeStrobe;
    assign StorageReadEnable = r_readEnable;
    assign TxData            = r_txData;
    assign TxStart           = r_txStart;
    assign ByteCount         = r_byteCount;
    assign Busy              = (r_state != c_IDLE);
    assign Done              = r_done;
    assign TimedOut          = r_timedOut;
    assign SeqState          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_sequencer
// Purpose  : Directed bench for capture_sequencer with a storage and UART model.
// Revision : 1.0  initial release
// ============================================================================
module tb_capture_sequencer;

    localparam int NBYTES = 12;
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_WAIT_TRIG = 4'd2;
    localparam logic [3:0] ST_STROBE    = 4'd3;
    localparam logic [3:0] ST_READ_REQ  = 4'd5;
    localparam logic [3:0] ST_TX_WAIT   = 4'd7;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ArmCmd;
    logic        AbortCmd;
    logic        TrigEnable;
    logic        ExtTrigger;
    logic [1:0]  StorageState;
    logic        FifoNotFull;
    logic        DataReadyToSend;
    logic [7:0]  StorageDataIn;
    logic        StorageDataValid;
    logic        TxBusy;
    logic        WriteStrobe;
    logic        StorageReadEnable;
    logic [7:0]  TxData;
    logic        TxStart;
    logic [15:0] ByteCount;
    logic        Busy;
    logic        Done;
    logic        TimedOut;
    logic [3:0]  SeqState;

    int assertCount = 0;
    int failCount   = 0;

    capture_sequencer #(
        .STROBE_LEN   (4),
        .TRIG_TIMEOUT (100),
        .TRIG_CNT_W   (8),
        .VALID_TIMEOUT(4),
        .BYTE_CNT_W   (16)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .ArmCmd           (ArmCmd),
        .AbortCmd         (AbortCmd),
        .TrigEnable       (TrigEnable),
        .ExtTrigger       (ExtTrigger),
        .StorageState     (StorageState),
        .FifoNotFull      (FifoNotFull),
        .DataReadyToSend  (DataReadyToSend),
        .StorageDataIn    (StorageDataIn),
        .StorageDataValid (StorageDataValid),
        .TxBusy           (TxBusy),
        .WriteStrobe      (WriteStrobe),
        .StorageReadEnable(StorageReadEnable),
        .TxData           (TxData),
        .TxStart          (TxStart),
        .ByteCount        (ByteCount),
        .Busy             (Busy),
        .Done             (Done),
        .TimedOut         (TimedOut),
        .SeqState         (SeqState)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] storeByte(input int idx);
        case (idx)
            0:       storeByte = 8'hFF;
            1:       storeByte = 8'h80;
            2:       storeByte = 8'h7F;
            3:       storeByte = 8'h00;
            4:       storeByte = 8'h12;
            5:       storeByte = 8'h34;
            6:       storeByte = 8'h56;
            7:       storeByte = 8'h78;
            8:       storeByte = 8'h9A;
            9:       storeByte = 8'hBC;
            10:      storeByte = 8'hDE;
            default: storeByte = 8'hF0;
        endcase
    endfunction

    // Storage model: strobe starts a 10-cycle fill, then bytes are served
    // one cycle after each read request; returns to ready once drained.
    logic [1:0] sState;
    int         fillCnt;
    int         rdIdx;
    logic       sValid;
    logic [7:0] sData;

    always @(posedge Clock) begin
        if (Reset) begin
            sState  <= 2'b00;
            fillCnt <= 0;
            rdIdx   <= 0;
            sValid  <= 1'b0;
            sData   <= 8'h00;
        end else begin
            sValid <= 1'b0;
            case (sState)
                2'b00: if (WriteStrobe) begin
                    sState  <= 2'b01;
                    fillCnt <= 10;
                    rdIdx   <= 0;
                end
                2'b01: if (fillCnt == 0) sState <= 2'b10; else fillCnt <= fillCnt - 1;
                default: begin
                    if (StorageReadEnable && rdIdx < NBYTES) begin
                        sData  <= storeByte(rdIdx);
                        sValid <= 1'b1;
                        rdIdx  <= rdIdx + 1;
                    end else if (rdIdx >= NBYTES && !sValid) begin
                        sState <= 2'b00;
                    end
                end
            endcase
        end
    end

    assign StorageState     = sState;
    assign DataReadyToSend  = (sState == 2'b10) && (rdIdx < NBYTES);
    assign StorageDataIn    = sData;
    assign StorageDataValid = sValid;
    assign FifoNotFull      = 1'b1;

    // UART model: busy for busyLen cycles after each start pulse.
    int busyLen = 3;
    int busyCnt;

    always @(posedge Clock) begin
        if (Reset)              busyCnt <= 0;
        else if (TxStart)       busyCnt <= busyLen;
        else if (busyCnt > 0)   busyCnt <= busyCnt - 1;
    end

    assign TxBusy = (busyCnt != 0);

    // Event monitor sampled on the falling edge.
    int         strobeCycles = 0;
    int         rePulses     = 0;
    int         reB2B        = 0;
    int         reBusy       = 0;
    int         txCount      = 0;
    int         donePulses   = 0;
    int         toPulses     = 0;
    logic       prevRe       = 1'b0;
    logic [7:0] txLog [256];

    always @(negedge Clock) begin
        if (WriteStrobe) strobeCycles <= strobeCycles + 1;
        if (StorageReadEnable) begin
            rePulses <= rePulses + 1;
            if (prevRe) reB2B  <= reB2B + 1;
            if (TxBusy) reBusy <= reBusy + 1;
        end
        prevRe <= StorageReadEnable;
        if (TxStart && txCount < 256) begin
            txLog[txCount] <= TxData;
            txCount        <= txCount + 1;
        end
        if (Done)     donePulses <= donePulses + 1;
        if (TimedOut) toPulses   <= toPulses + 1;
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic pulseArm();
        ArmCmd = 1'b1;
        step();
        ArmCmd = 1'b0;
    endtask

    task automatic waitState(input logic [3:0] st, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (SeqState == st) seen = 1'b1;
            else step();
        end
        checkEq(tag, 32'(seen), 32'd1);
    endtask

    task automatic waitDone(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (Done) seen = 1'b1;
        end
        checkEq(tag, 32'(seen), 32'd1);
    endtask

    task automatic checkBytes(input int start, input string tag);
        for (int i = 0; i < NBYTES; i++) begin
            checkEq(tag, 32'(txLog[(start + i) % 256]), 32'(storeByte(i)));
        end
    endtask

    int snapStrobe, snapRe, snapB2B, snapBusy, snapTx, snapDone, snapTo;

    task automatic snapshot();
        snapStrobe = strobeCycles;
        snapRe     = rePulses;
        snapB2B    = reB2B;
        snapBusy   = reBusy;
        snapTx     = txCount;
        snapDone   = donePulses;
        snapTo     = toPulses;
    endtask

    initial begin
        int k;
        bit hit;
        Reset = 1'b1; ArmCmd = 1'b0; AbortCmd = 1'b0;
        TrigEnable = 1'b0; ExtTrigger = 1'b0;
        repeat (3) step();
        checkEq("rstState",  32'(SeqState), 32'(ST_IDLE));
        checkEq("rstBusy",   32'(Busy), 32'd0);
        checkEq("rstStrobe", 32'(WriteStrobe), 32'd0);
        checkEq("rstCount",  32'(ByteCount), 32'd0);
        checkEq("rstTxData", 32'(TxData), 32'd0);
        Reset = 1'b0;
        step();

        // Untriggered acquisition with signature plus payload.
        snapshot();
        pulseArm();
        waitDone(2000, "t1Done");
        step();
        checkEq("t1StrobeLen", 32'(strobeCycles - snapStrobe), 32'd4);
        checkEq("t1TxStarts",  32'(txCount - snapTx), 32'd12);
        checkBytes(snapTx, "t1Byte");
        checkEq("t1ByteCount", 32'(ByteCount), 32'd12);
        checkEq("t1DoneCount", 32'(donePulses - snapDone), 32'd1);
        checkEq("t1Idle",      32'(SeqState), 32'(ST_IDLE));
        checkEq("t1Busy",      32'(Busy), 32'd0);

        // Trigger timeout with no trigger edge.
        TrigEnable = 1'b1;
        snapshot();
        pulseArm();
        waitState(ST_WAIT_TRIG, 20, "t2EnterTrig");
        k = 0;
        hit = 1'b0;
        for (int i = 1; i <= 200 && !hit; i++) begin
            step();
            if (TimedOut) begin
                hit = 1'b1;
                k = i;
            end
        end
        checkEq("t2TimeoutCycle", 32'(k), 32'd100);
        checkEq("t2BusyAfter",    32'(Busy), 32'd0);
        step();
        checkEq("t2PulseWidth",   32'(TimedOut), 32'd0);
        checkEq("t2NoStrobe",     32'(strobeCycles - snapStrobe), 32'd0);
        checkEq("t2ToCount",      32'(toPulses - snapTo), 32'd1);

        // Trigger edge on the same cycle the timeout expires.
        snapshot();
        pulseArm();
        waitState(ST_WAIT_TRIG, 20, "t3EnterTrig");
        for (int i = 1; i <= 99; i++) step();
        checkEq("t3StillWaiting", 32'(SeqState), 32'(ST_WAIT_TRIG));
        ExtTrigger = 1'b1;
        step();
        checkEq("t3Strobe",    32'(SeqState), 32'(ST_STROBE));
        checkEq("t3NoTimeout", 32'(TimedOut), 32'd0);
        waitDone(2000, "t3Done");
        step();
        checkEq("t3ToCount",   32'(toPulses - snapTo), 32'd0);
        checkEq("t3StrobeLen", 32'(strobeCycles - snapStrobe), 32'd4);
        checkBytes(snapTx, "t3Byte");
        checkEq("t3ByteCount", 32'(ByteCount), 32'd12);
        ExtTrigger = 1'b0;
        TrigEnable = 1'b0;

        // Slow UART: reads must wait for the transmitter.
        busyLen = 50;
        snapshot();
        pulseArm();
        waitDone(5000, "t4Done");
        step();
        checkEq("t4ReWhileBusy", 32'(reBusy - snapBusy), 32'd0);
        checkEq("t4ReBackToBack",32'(reB2B - snapB2B), 32'd0);
        checkEq("t4ReCount",     32'(rePulses - snapRe), 32'd12);
        checkBytes(snapTx, "t4Byte");
        checkEq("t4ByteCount",   32'(ByteCount), 32'd12);
        busyLen = 3;

        // Abort in READ_REQ with 8 bytes left in storage.
        pulseArm();
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (SeqState == ST_READ_REQ && ByteCount == 16'd4) hit = 1'b1;
            else step();
        end
        checkEq("t5ReachReq", 32'(hit), 32'd1);
        snapshot();
        AbortCmd = 1'b1;
        step();
        AbortCmd = 1'b0;
        waitState(ST_IDLE, 1000, "t5BackIdle");
        checkEq("t5FlushReads",  32'(rePulses - snapRe), 32'd8);
        checkEq("t5NoTxStart",   32'(txCount - snapTx), 32'd0);
        checkEq("t5CountFrozen", 32'(ByteCount), 32'd4);
        checkEq("t5NoDone",      32'(donePulses - snapDone), 32'd0);
        checkEq("t5StorageRdy",  32'(StorageState), 32'd0);
        checkEq("t5FlushB2B",    32'(reB2B - snapB2B), 32'd0);
        snapshot();
        pulseArm();
        waitDone(2000, "t5RearmDone");
        checkBytes(snapTx, "t5RearmByte");
        checkEq("t5RearmCount", 32'(ByteCount), 32'd12);
        step();

        // Reset during TX_WAIT, then simultaneous Arm and Abort in IDLE.
        pulseArm();
        waitState(ST_TX_WAIT, 500, "t6ReachTxWait");
        Reset = 1'b1;
        step();
        checkEq("t6State",   32'(SeqState), 32'(ST_IDLE));
        checkEq("t6TxData",  32'(TxData), 32'd0);
        checkEq("t6TxStart", 32'(TxStart), 32'd0);
        checkEq("t6Count",   32'(ByteCount), 32'd0);
        checkEq("t6Busy",    32'(Busy), 32'd0);
        checkEq("t6Others",  32'({WriteStrobe, StorageReadEnable, Done, TimedOut}), 32'd0);
        Reset = 1'b0;
        step();
        ArmCmd = 1'b1;
        AbortCmd = 1'b1;
        step();
        ArmCmd = 1'b0;
        AbortCmd = 1'b0;
        checkEq("t6ArmAbortState", 32'(SeqState), 32'(ST_IDLE));
        checkEq("t6ArmAbortBusy",  32'(Busy), 32'd0);
        step();
        checkEq("t6ArmAbortLater", 32'(SeqState), 32'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
